// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master among several clients, with a
// per-transaction timeout and a CS-idle guard gap before the next launch.
module spi_master_arbiter #(
   parameter int REQUESTERS   = 4,
   parameter int PACK_LENGTH  = 8,
   parameter int GUARD_CLKS   = 4,
   parameter int TIMEOUT_CLKS = 1024
) (
   input  logic                              IN_CLOCK,
   input  logic                              IN_RESET,
   input  logic [REQUESTERS-1:0]             IN_REQ,
   input  logic [REQUESTERS*PACK_LENGTH-1:0] IN_REQ_DATA,
   output logic [REQUESTERS-1:0]             OUT_GRANT,
   output logic [REQUESTERS-1:0]             OUT_ACK,
   output logic [PACK_LENGTH-1:0]            OUT_RESP_DATA,
   output logic                              OUT_ERROR,
   output logic                              OUT_BUSY,
   output logic                              OUT_LAUNCH,
   output logic [PACK_LENGTH-1:0]            OUT_MASTER_DATA,
   input  logic                              IN_CS,
   input  logic [PACK_LENGTH-1:0]            IN_MASTER_RECEIVE_DATA,
   input  logic                              IN_MASTER_ACTION_DONE
);

   // state       | meaning
   // S_IDLE      | no transaction; arbitrate among IN_REQ from r_ptr upward
   // S_LAUNCH    | OUT_LAUNCH held high until the master pulls CS low
   // S_WAIT_DONE | waiting for a fresh rising edge of the master's done
   // S_RESP      | issue OUT_ACK/OUT_RESP_DATA/OUT_ERROR, advance r_ptr
   // S_GUARD     | count GUARD_CLKS cycles of CS high before re-arbitrating

   localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
   localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam int GW = 8;

   localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT_CLKS - 1);
   localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CLKS);
   localparam logic [IW-1:0] LAST_IDX   = IW'(REQUESTERS - 1);
   localparam logic [IW:0]   NREQ       = (IW+1)'(REQUESTERS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_DONE,
      S_RESP,
      S_GUARD
   } state_t;

   state_t                  r_state;
   logic [IW-1:0]           r_ptr;
   logic [IW-1:0]           r_gidx;
   logic [TW-1:0]           r_tmo;
   logic [GW-1:0]           r_guard;
   logic                    r_done_d;
   logic                    r_err;
   logic [PACK_LENGTH-1:0]  r_rx;

   logic [2*REQUESTERS-1:0] w_dbl;
   logic [REQUESTERS-1:0]   w_rot;
   logic [IW-1:0]           w_off;
   logic [IW:0]             w_sum;
   logic [IW:0]             w_wrap;
   logic [IW-1:0]           w_pick;
   logic                    w_req_any;
   logic [REQUESTERS-1:0]   w_onehot;
   logic [PACK_LENGTH-1:0]  w_tx;
   logic                    w_done_rise;

   // Rotate requests so bit 0 is the client at r_ptr; the lowest set bit wins.
   always_comb begin
      w_dbl     = {IN_REQ, IN_REQ} >> r_ptr;
      w_rot     = w_dbl[REQUESTERS-1:0];
      w_off     = '0;
      w_req_any = 1'b0;
      for (int k = REQUESTERS - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off     = IW'(k);
            w_req_any = 1'b1;
         end
      end
      w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
      w_wrap = w_sum - NREQ;
      w_pick = (w_sum >= NREQ) ? w_wrap[IW-1:0] : w_sum[IW-1:0];
      w_onehot = '0;
      w_tx     = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         if (w_pick == IW'(k)) begin
            w_onehot[k] = 1'b1;
            w_tx        = IN_REQ_DATA[k*PACK_LENGTH +: PACK_LENGTH];
         end
      end
   end

   assign w_done_rise = IN_MASTER_ACTION_DONE & ~r_done_d;

   always_ff @(posedge IN_CLOCK) begin
      if (IN_RESET) begin
         r_state         <= S_IDLE;
         r_ptr           <= '0;
         r_gidx          <= '0;
         r_tmo           <= '0;
         r_guard         <= '0;
         r_done_d        <= 1'b0;
         r_err           <= 1'b0;
         r_rx            <= '0;
         OUT_GRANT       <= '0;
         OUT_ACK         <= '0;
         OUT_RESP_DATA   <= '0;
         OUT_ERROR       <= 1'b0;
         OUT_BUSY        <= 1'b0;
         OUT_LAUNCH      <= 1'b0;
         OUT_MASTER_DATA <= '0;
      end else begin
         r_done_d  <= IN_MASTER_ACTION_DONE;
         OUT_ACK   <= '0;
         OUT_ERROR <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req_any) begin
                  OUT_GRANT       <= w_onehot;
                  OUT_MASTER_DATA <= w_tx;
                  OUT_LAUNCH      <= 1'b1;
                  OUT_BUSY        <= 1'b1;
                  r_gidx          <= w_pick;
                  r_tmo           <= TMO_LOAD;
                  r_err           <= 1'b0;
                  r_state         <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               if (r_tmo == '0) begin
                  OUT_LAUNCH <= 1'b0;
                  r_rx       <= '0;
                  r_err      <= 1'b1;
                  r_state    <= S_RESP;
               end else begin
                  r_tmo <= r_tmo - 1'b1;
                  if (!IN_CS) begin
                     OUT_LAUNCH <= 1'b0;
                     r_state    <= S_WAIT_DONE;
                  end
               end
            end
            S_WAIT_DONE: begin
               // A completed transfer wins over a timeout landing on the same cycle.
               if (w_done_rise) begin
                  r_rx    <= IN_MASTER_RECEIVE_DATA;
                  r_state <= S_RESP;
               end else if (r_tmo == '0) begin
                  r_rx    <= '0;
                  r_err   <= 1'b1;
                  r_state <= S_RESP;
               end else begin
                  r_tmo <= r_tmo - 1'b1;
               end
            end
            S_RESP: begin
               OUT_ACK       <= OUT_GRANT;
               OUT_RESP_DATA <= r_rx;
               OUT_ERROR     <= r_err;
               OUT_GRANT     <= '0;
               r_ptr         <= (r_gidx == LAST_IDX) ? '0 : r_gidx + 1'b1;
               r_guard       <= GUARD_LOAD;
               r_state       <= S_GUARD;
            end
            S_GUARD: begin
               if (IN_CS) begin
                  if (r_guard == GW'(1)) begin
                     OUT_BUSY <= 1'b0;
                     r_state  <= S_IDLE;
                  end else begin
                     r_guard <= r_guard - 1'b1;
                  end
               end
            end
            default: begin
               OUT_BUSY   <= 1'b0;
               OUT_LAUNCH <= 1'b0;
               OUT_GRANT  <= '0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule
